// File: rtl/router_rr_pkg.sv
// Shared definitions for the round-robin NoC router: port indices and a saturating counter helper.
package router_rr_pkg;

    typedef enum logic [2:0] {
        PORT_NORTH = 3'd0,
        PORT_SOUTH = 3'd1,
        PORT_EAST  = 3'd2,
        PORT_WEST  = 3'd3,
        PORT_LOCAL = 3'd4
    } port_e;

    localparam int STAT_WIDTH = 16;

    // Adds a small per-cycle increment to a 16-bit statistic, clamping at all-ones.
    function automatic logic [15:0] satAdd16(input logic [15:0] base, input logic [3:0] inc);
        logic [16:0] sum;
        sum = {1'b0, base} + {13'b0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/router_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
module rr_arbiter
    import router_rr_pkg::*;
#(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req_i,
    input  logic         enable_i,
    output logic [N-1:0] grant_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          found;

    // Two passes give the cyclic search without variable indexing: [ptr..N-1] first, then [0..ptr-1].
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (enable_i && !found && req_i[i] && (i >= int'(ptr_q))) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
                ptr_d      = (i == N - 1) ? '0 : IW'(i + 1);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (enable_i && !found && req_i[i] && (i < int'(ptr_q))) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
                ptr_d      = (i == N - 1) ? '0 : IW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/router_rr_fifo.sv
// Per-input flit FIFO: 2^DEPTH_LOG2 entries, wrap-around pointers, occupancy count.
module router_rr_fifo
    import router_rr_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr_q;
    logic [DEPTH_LOG2-1:0] rdPtr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (pop_i && !push_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop_i)  rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wrPtr_q] <= data_i;
    end

    assign head_o  = mem_q[rdPtr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));

endmodule

// File: rtl/router_rr.sv
// NoC router with per-input FIFOs, per-output round-robin arbitration and parallel table lookups.
// Optional drop statistics counter enabled by defining ROUTER_STATS_EN.
module router_rr
    import router_rr_pkg::*;
#(
    parameter int ID               = -1,
    parameter int SIZE             = 8,
    parameter int PORT_COUNT       = 5,
    parameter int DESTINATION_BITS = 4,
    parameter int PORT_BITS        = 4,
    parameter int DEPTH_LOG2       = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [PORT_COUNT-1:0]                rx_req,
    output logic [PORT_COUNT-1:0]                rx_ack,
    input  logic [PORT_COUNT*SIZE-1:0]           rx_data,
    output logic [PORT_COUNT-1:0]                tx_req,
    input  logic [PORT_COUNT-1:0]                tx_ack,
    output logic [PORT_COUNT*SIZE-1:0]           tx_data,
    output logic [PORT_COUNT*DESTINATION_BITS-1:0] table_addr,
    input  logic [PORT_COUNT*PORT_BITS-1:0]      table_data
`ifdef ROUTER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]                drop_count
`endif
);

    logic [PORT_COUNT-1:0] fifoEmpty;
    logic [PORT_COUNT-1:0] fifoFull;
    logic [PORT_COUNT-1:0] fifoPush;
    logic [PORT_COUNT-1:0] fifoPop;
    logic [PORT_COUNT-1:0] drop;
    logic [PORT_COUNT-1:0] slotFree;
    logic [SIZE-1:0]       head     [PORT_COUNT];
    logic [PORT_BITS-1:0]  target   [PORT_COUNT];
    logic [PORT_COUNT-1:0] outReq   [PORT_COUNT];
    logic [PORT_COUNT-1:0] grant    [PORT_COUNT];
    logic [SIZE-1:0]       txData_d [PORT_COUNT];
    logic [SIZE-1:0]       txData_q [PORT_COUNT];
    logic [PORT_COUNT-1:0] txReq_q;

    for (genvar i = 0; i < PORT_COUNT; i++) begin : g_input
        router_rr_fifo #(
            .WIDTH      (SIZE),
            .DEPTH_LOG2 (DEPTH_LOG2)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (fifoPush[i]),
            .data_i  (rx_data[SIZE*i +: SIZE]),
            .pop_i   (fifoPop[i]),
            .head_o  (head[i]),
            .empty_o (fifoEmpty[i]),
            .full_o  (fifoFull[i])
        );

        assign rx_ack[i]   = !fifoFull[i];
        assign fifoPush[i] = rx_req[i] && !fifoFull[i];
        assign table_addr[DESTINATION_BITS*i +: DESTINATION_BITS] = head[i][DESTINATION_BITS-1:0];
        assign target[i]   = table_data[PORT_BITS*i +: PORT_BITS];
        assign drop[i]     = !fifoEmpty[i] && (int'(target[i]) >= PORT_COUNT);
    end

    // Each input raises a request toward exactly one output, so a FIFO pops at most once per cycle.
    always_comb begin
        for (int j = 0; j < PORT_COUNT; j++) begin
            outReq[j] = '0;
            for (int i = 0; i < PORT_COUNT; i++) begin
                outReq[j][i] = !fifoEmpty[i] && (int'(target[i]) == j);
            end
        end
    end

    assign slotFree = ~txReq_q | tx_ack;

    for (genvar j = 0; j < PORT_COUNT; j++) begin : g_output
        rr_arbiter #(
            .N (PORT_COUNT)
        ) u_arbiter (
            .clk      (clk),
            .reset    (reset),
            .req_i    (outReq[j]),
            .enable_i (slotFree[j]),
            .grant_o  (grant[j])
        );

        assign tx_data[SIZE*j +: SIZE] = txData_q[j];
    end

    always_comb begin
        fifoPop = drop;
        for (int j = 0; j < PORT_COUNT; j++) begin
            txData_d[j] = '0;
            for (int i = 0; i < PORT_COUNT; i++) begin
                if (grant[j][i]) begin
                    fifoPop[i]  = 1'b1;
                    txData_d[j] = txData_d[j] | head[i];
                end
            end
        end
    end

    // Output registers hold req/data until the downstream ack is seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            txReq_q <= '0;
            for (int j = 0; j < PORT_COUNT; j++) txData_q[j] <= '0;
        end else begin
            for (int j = 0; j < PORT_COUNT; j++) begin
                if (|grant[j]) begin
                    txReq_q[j]  <= 1'b1;
                    txData_q[j] <= txData_d[j];
                end else if (tx_ack[j]) begin
                    txReq_q[j]  <= 1'b0;
                end
            end
        end
    end

    assign tx_req = txReq_q;

`ifdef ROUTER_STATS_EN
    logic [STAT_WIDTH-1:0] dropCount_q;
    logic [3:0]            dropNum;

    always_comb begin
        dropNum = '0;
        for (int i = 0; i < PORT_COUNT; i++) dropNum = dropNum + 4'(drop[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) dropCount_q <= '0;
        else       dropCount_q <= satAdd16(dropCount_q, dropNum);
    end

    assign drop_count = dropCount_q;
`endif

endmodule
